// File: rtl/mc_main_dec.sv
// Multicycle Moore main decoder: sequences each instruction over 3-5 cycles.
// Define MCDEC_MEMWAIT_EN to add the memReady handshake and wait-timeout fault.
module mc_main_dec #(
  parameter int OPW      = 5,
  parameter int ALUCW    = 4,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   opCode,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             irWrite,
  output logic             iorD,
  output logic             memWrite,
  output logic             regDst,
  output logic             regWrite,
  output logic             memToReg,
  output logic             aluSrcA,
  output logic             branch,
  output logic             jalSelect,
  output logic             jrSelect,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       pcSrc,
  output logic [ALUCW-1:0] aluControl,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             fault
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_IMMEX  = 4'd8;
  localparam logic [3:0] S_IMMWB  = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;
  localparam logic [3:0] S_HALT   = 4'd15;

  logic [3:0] next_state;
  logic [4:0] op;
  logic       op_hi;
  logic       ready;
  logic       timeout;
  logic [3:0] alu_code;

  assign op = opCode[4:0];

  // Any opcode bit above bit 4 makes the instruction illegal.
  generate
    if (OPW > 5) begin : g_op_hi
      assign op_hi = |opCode[OPW-1:5];
    end else begin : g_no_op_hi
      assign op_hi = 1'b0;
    end
  endgenerate

`ifdef MCDEC_MEMWAIT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] wait_cnt;
  logic          in_wait;

  assign ready   = memReady;
  assign in_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // Timeout fires on the cycle whose increment would reach WAIT_MAX.
  assign timeout = in_wait && !memReady && (wait_cnt == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if (in_wait && !memReady) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (timeout) begin
      fault <= 1'b1;
    end
  end
`else
  logic [1:0] unused_cfg;

  assign ready      = 1'b1;
  assign timeout    = 1'b0;
  assign fault      = 1'b0;
  assign unused_cfg = {memReady, WAIT_MAX > 0};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE && next_state == S_HALT) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (ready) next_state = S_DECODE; else if (timeout) next_state = S_HALT;
      S_DECODE: begin
        if (op_hi) begin
          next_state = S_HALT;
        end else if (op == 5'b10010) begin
          next_state = S_JR;
        end else if (op >= 5'b01000 && op <= 5'b10100) begin
          next_state = S_EXEC;
        end else begin
          case (op)
            5'b11000, 5'b11001: next_state = S_IMMEX;
            5'b11010, 5'b11011: next_state = S_MEMADR;
            5'b11100, 5'b11101: next_state = S_BRANCH;
            5'b00000:           next_state = S_JUMP;
            5'b00111:           next_state = S_JAL;
            default:            next_state = S_HALT;
          endcase
        end
      end
      S_MEMADR: next_state = op[0] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ready) next_state = S_MEMWB; else if (timeout) next_state = S_HALT;
      S_MEMWR:  if (ready) next_state = S_FETCH; else if (timeout) next_state = S_HALT;
      S_EXEC:   next_state = S_ALUWB;
      S_IMMEX:  next_state = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_JR: next_state = S_FETCH;
      default:  next_state = S_HALT;
    endcase
  end

  always_comb begin
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    iorD      = 1'b0;
    memWrite  = 1'b0;
    regDst    = 1'b0;
    regWrite  = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    branch    = 1'b0;
    jalSelect = 1'b0;
    jrSelect  = 1'b0;
    aluSrcB   = 2'b00;
    pcSrc     = 2'b00;
    alu_code  = 4'b0000;
    case (state)
      S_FETCH: begin
        aluSrcB = 2'b01;
        irWrite = ready;
        pcWrite = ready;
      end
      S_DECODE: aluSrcB = 2'b11;
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMRD: iorD = 1'b1;
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEMWR: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
      end
      S_EXEC: begin
        aluSrcA  = 1'b1;
        alu_code = op[3:0] - 4'd8;
      end
      S_ALUWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      S_IMMEX: begin
        aluSrcA  = 1'b1;
        aluSrcB  = 2'b10;
        alu_code = {3'b000, op[0]};
      end
      S_IMMWB: regWrite = 1'b1;
      S_BRANCH: begin
        aluSrcA  = 1'b1;
        alu_code = 4'b0001;
        pcSrc    = 2'b01;
        branch   = 1'b1;
        pcWrite  = op[0] ? ~zero : zero;
      end
      S_JUMP: begin
        pcSrc   = 2'b10;
        pcWrite = 1'b1;
      end
      S_JAL: begin
        pcSrc     = 2'b10;
        pcWrite   = 1'b1;
        regWrite  = 1'b1;
        jalSelect = 1'b1;
      end
      S_JR: begin
        pcSrc    = 2'b11;
        pcWrite  = 1'b1;
        jrSelect = 1'b1;
      end
      default: ;
    endcase
  end

  assign aluControl = ALUCW'(alu_code);

endmodule

// File: tb/tb_mc_main_dec.sv
// Self-checking bench for mc_main_dec: per-cycle expected output vectors are
// queued with their stimulus and compared as the decoder steps through them.
module tb_mc_main_dec;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] op_code = 5'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       pc_write, ir_write, ior_d, mem_write, reg_dst, reg_write;
  logic       mem_to_reg, alu_src_a, branch, jal_select, jr_select;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control, state;
  logic       illegal, fault;

`ifdef MCDEC_MEMWAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  mc_main_dec dut (
    .clk(clk), .reset(reset), .opCode(op_code), .zero(zero), .memReady(mem_ready),
    .pcWrite(pc_write), .irWrite(ir_write), .iorD(ior_d), .memWrite(mem_write),
    .regDst(reg_dst), .regWrite(reg_write), .memToReg(mem_to_reg), .aluSrcA(alu_src_a),
    .branch(branch), .jalSelect(jal_select), .jrSelect(jr_select), .aluSrcB(alu_src_b),
    .pcSrc(pc_src), .aluControl(alu_control), .state(state), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, iord, memw, regdst, regw, memtoreg, srca, br, jal, jr;
    logic [1:0] srcb, pcsrc;
    logic [3:0] aluc;
    logic       ill, flt;
  } outs_t;

  int    n_checks = 0;
  int    n_fails  = 0;
  outs_t exp_q[$];
  logic  rdy_q[$];
  logic  z_q[$];

  function automatic outs_t capture();
    outs_t o;
    o = {state, pc_write, ir_write, ior_d, mem_write, reg_dst, reg_write, mem_to_reg,
         alu_src_a, branch, jal_select, jr_select, alu_src_b, pc_src, alu_control,
         illegal, fault};
    return o;
  endfunction

  function automatic outs_t xs(input logic [3:0] s);
    outs_t o;
    o    = '0;
    o.st = s;
    return o;
  endfunction

  // Without the handshake, FETCH always behaves as if memory were ready.
  function automatic outs_t x_fetch(input logic rdy);
    outs_t o;
    o      = xs(4'd0);
    o.srcb = 2'b01;
    o.irw  = WAIT_EN ? rdy : 1'b1;
    o.pcw  = WAIT_EN ? rdy : 1'b1;
    return o;
  endfunction

  function automatic outs_t x_decode();
    outs_t o;
    o      = xs(4'd1);
    o.srcb = 2'b11;
    return o;
  endfunction

  task automatic push(input logic rdy, input logic z, input outs_t e);
    rdy_q.push_back(rdy);
    z_q.push_back(z);
    exp_q.push_back(e);
  endtask

  // Entered just after a falling edge; samples mid-cycle, returns at the next falling edge.
  task automatic drive_cycle(input logic rdy, input logic z, output outs_t o);
    mem_ready = rdy;
    zero      = z;
    #1;
    o = capture();
    @(negedge clk);
  endtask

  task automatic test_reset();
    outs_t o;
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    o = capture();
    n_checks++;
    if (o !== x_fetch(1'b1)) begin
      n_fails++;
      $display("[TB] FAIL reset_ready1: got %h, expected %h", o, x_fetch(1'b1));
    end
    mem_ready = 1'b0;
    #1;
    o = capture();
    n_checks++;
    if (o !== x_fetch(1'b0)) begin
      n_fails++;
      $display("[TB] FAIL reset_ready0: got %h, expected %h", o, x_fetch(1'b0));
    end
    @(negedge clk);
    mem_ready = 1'b1;
    reset     = 1'b0;
  endtask

  task automatic test_rtype();
    logic [4:0] ops [5] = '{5'b01000, 5'b01111, 5'b10000, 5'b10011, 5'b10100};
    logic [3:0] acs [5] = '{4'b0000, 4'b0111, 4'b1000, 4'b1011, 4'b1100};
    outs_t e, o;
    for (int i = 0; i < 5; i++) begin
      op_code = ops[i];
      push(1'b1, 1'b0, x_fetch(1'b1));
      push(1'b1, 1'b0, x_decode());
      e = xs(4'd6); e.srca = 1'b1; e.aluc = acs[i];
      push(1'b1, 1'b0, e);
      e = xs(4'd7); e.regdst = 1'b1; e.regw = 1'b1;
      push(1'b1, 1'b0, e);
      while (exp_q.size() != 0) begin
        drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
        e = exp_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL rtype op=%b: got %h, expected %h", ops[i], o, e);
        end
      end
    end
  endtask

  task automatic test_imm();
    outs_t e, o;
    for (int i = 0; i < 2; i++) begin
      op_code = (i == 0) ? 5'b11000 : 5'b11001;
      push(1'b1, 1'b0, x_fetch(1'b1));
      push(1'b1, 1'b0, x_decode());
      e = xs(4'd8); e.srca = 1'b1; e.srcb = 2'b10; e.aluc = (i == 0) ? 4'b0000 : 4'b0001;
      push(1'b1, 1'b0, e);
      e = xs(4'd9); e.regw = 1'b1;
      push(1'b1, 1'b0, e);
      while (exp_q.size() != 0) begin
        drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
        e = exp_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL imm op=%b: got %h, expected %h", op_code, o, e);
        end
      end
    end
  endtask

  task automatic test_mem();
    outs_t e, o, adr;
    adr = xs(4'd2); adr.srca = 1'b1; adr.srcb = 2'b10;
    // lw with a stalled fetch and a 3-cycle stall in MEMRD
    op_code = 5'b11010;
    push(1'b0, 1'b0, x_fetch(1'b0));
    if (WAIT_EN) push(1'b1, 1'b0, x_fetch(1'b1));
    push(1'b1, 1'b0, x_decode());
    push(1'b1, 1'b0, adr);
    e = xs(4'd3); e.iord = 1'b1;
    push(1'b0, 1'b0, e);
    if (WAIT_EN) begin
      push(1'b0, 1'b0, e);
      push(1'b0, 1'b0, e);
      push(1'b1, 1'b0, e);
    end
    e = xs(4'd4); e.regw = 1'b1; e.memtoreg = 1'b1;
    push(1'b1, 1'b0, e);
    // sw with a 1-cycle stall in MEMWR
    push(1'b1, 1'b0, x_fetch(1'b1));
    push(1'b1, 1'b0, x_decode());
    push(1'b1, 1'b0, adr);
    e = xs(4'd5); e.iord = 1'b1; e.memw = 1'b1;
    push(1'b0, 1'b0, e);
    if (WAIT_EN) push(1'b1, 1'b0, e);
    for (int c = 0; exp_q.size() != 0; c++) begin
      if (exp_q[0].st == 4'd1) op_code = (c < 4 + 5 * int'(WAIT_EN)) ? 5'b11010 : 5'b11011;
      drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fails++;
        $display("[TB] FAIL mem cycle %0d: got %h, expected %h", c, o, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [4:0] ops [4] = '{5'b11100, 5'b11100, 5'b11101, 5'b11101};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       pws [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    outs_t e, o;
    for (int i = 0; i < 4; i++) begin
      op_code = ops[i];
      push(1'b1, zs[i], x_fetch(1'b1));
      push(1'b1, zs[i], x_decode());
      e = xs(4'd10); e.srca = 1'b1; e.aluc = 4'b0001; e.pcsrc = 2'b01; e.br = 1'b1; e.pcw = pws[i];
      push(1'b1, zs[i], e);
      while (exp_q.size() != 0) begin
        drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
        e = exp_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL branch op=%b zero=%b: got %h, expected %h", ops[i], zs[i], o, e);
        end
      end
    end
  endtask

  task automatic test_jumps();
    logic [4:0] ops [3] = '{5'b00000, 5'b10010, 5'b00111};
    outs_t e, o, jal_e;
    jal_e = xs(4'd12); jal_e.pcsrc = 2'b10; jal_e.pcw = 1'b1; jal_e.regw = 1'b1; jal_e.jal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_code = ops[i];
      push(1'b1, 1'b0, x_fetch(1'b1));
      push(1'b1, 1'b0, x_decode());
      if (i == 0) begin
        e = xs(4'd11); e.pcsrc = 2'b10; e.pcw = 1'b1;
      end else if (i == 1) begin
        e = xs(4'd13); e.pcsrc = 2'b11; e.pcw = 1'b1; e.jr = 1'b1;
      end else begin
        e = jal_e;
      end
      push(1'b1, 1'b0, e);
      while (exp_q.size() != 0) begin
        drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
        e = exp_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL jump op=%b: got %h, expected %h", ops[i], o, e);
        end
      end
    end
    // jal aborted by a mid-cycle reset
    push(1'b1, 1'b0, x_fetch(1'b1));
    push(1'b1, 1'b0, x_decode());
    while (exp_q.size() != 0) begin
      drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fails++;
        $display("[TB] FAIL jal_abort_lead: got %h, expected %h", o, e);
      end
    end
    mem_ready = 1'b1;
    #1;
    o = capture();
    n_checks++;
    if (o !== jal_e) begin
      n_fails++;
      $display("[TB] FAIL jal_before_reset: got %h, expected %h", o, jal_e);
    end
    #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    #1;
    o = capture();
    n_checks++;
    if (o !== x_fetch(1'b0)) begin
      n_fails++;
      $display("[TB] FAIL reset_in_jal: got %h, expected %h", o, x_fetch(1'b0));
    end
    @(negedge clk);
    mem_ready = 1'b1;
    reset     = 1'b0;
  endtask

  task automatic test_illegal();
    logic [4:0] ops [4] = '{5'b00101, 5'b10101, 5'b11110, 5'b00001};
    outs_t e, o, h;
    h = xs(4'd15); h.ill = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_code = ops[i];
      push(1'b1, 1'b0, x_fetch(1'b1));
      push(1'b1, 1'b0, x_decode());
      push(1'b1, 1'b1, h);
      push(1'b0, 1'b0, h);
      push(1'b1, 1'b0, h);
      while (exp_q.size() != 0) begin
        drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
        e = exp_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fails++;
          $display("[TB] FAIL illegal op=%b: got %h, expected %h", ops[i], o, e);
        end
      end
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1;
      o = capture();
      n_checks++;
      if (o !== x_fetch(1'b1)) begin
        n_fails++;
        $display("[TB] FAIL illegal_cleared: got %h, expected %h", o, x_fetch(1'b1));
      end
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

`ifdef MCDEC_MEMWAIT_EN
  task automatic test_timeout();
    outs_t e, o, h;
    h = xs(4'd15); h.flt = 1'b1;
    for (int c = 0; c < 16; c++) push(1'b0, 1'b0, x_fetch(1'b0));
    push(1'b1, 1'b0, h);
    push(1'b0, 1'b1, h);
    for (int c = 0; exp_q.size() != 0; c++) begin
      drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fails++;
        $display("[TB] FAIL timeout cycle %0d: got %h, expected %h", c, o, e);
      end
    end
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    o = capture();
    n_checks++;
    if (o !== x_fetch(1'b1)) begin
      n_fails++;
      $display("[TB] FAIL fault_cleared: got %h, expected %h", o, x_fetch(1'b1));
    end
    @(negedge clk);
    reset = 1'b0;
    // memReady arrives on the 16th cycle: normal advance wins
    op_code = 5'b01000;
    for (int c = 0; c < 15; c++) push(1'b0, 1'b0, x_fetch(1'b0));
    push(1'b1, 1'b0, x_fetch(1'b1));
    push(1'b1, 1'b0, x_decode());
    e = xs(4'd6); e.srca = 1'b1;
    push(1'b1, 1'b0, e);
    e = xs(4'd7); e.regdst = 1'b1; e.regw = 1'b1;
    push(1'b1, 1'b0, e);
    for (int c = 0; exp_q.size() != 0; c++) begin
      drive_cycle(rdy_q.pop_front(), z_q.pop_front(), o);
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fails++;
        $display("[TB] FAIL ready_at_limit cycle %0d: got %h, expected %h", c, o, e);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] mc_main_dec bench start (wait handshake %0d)", WAIT_EN);
    test_reset();
    test_rtype();
    test_imm();
    test_mem();
    test_branch();
    test_jumps();
    test_illegal();
`ifdef MCDEC_MEMWAIT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
